cnn_row_sequencer: RTL
======================

// Module: cnn_row_sequencer
// PURPOSE
//  Control FSM for one cnn_layer. Drives the line buffer: vertical row loads, horizontal column rotation.
//  Marks each legal kernel window position and times capture of kernel results into the output-row register.
//  Presents each finished output row with a valid/accept handshake. Sits between the row source and the next layer.
// PARAMETERS
//  WIDTH          28  image columns (line-buffer width)
//  HEIGHT         28  image rows per frame
//  KERNAL_SIZE     3  square kernel edge; rows required before the first window
//  STRIDE          1  horizontal and vertical kernel step, >=1
//  KERNAL_LATENCY  2  cycles from kern_valid_o to the kernel result being ready, >=1
//  Derived:
//    OUT_W = (WIDTH-KERNAL_SIZE)/STRIDE+1
//    OUT_H = (HEIGHT-KERNAL_SIZE)/STRIDE+1
//    LEFTOVER = HEIGHT-KERNAL_SIZE-(OUT_H-1)*STRIDE
// PORTS
//  clock_i           in   1              single clock, rising edge
//  reset_i           in   1              asynchronous, active-low reset
//  in_row_valid_i    in   1              upstream row present on the datapath input
//  in_row_ready_o    out  1              sequencer accepts a row this cycle
//  shift_vert_o      out  1              load the row into the buffer (= in_row_valid_i & in_row_ready_o)
//  shift_horiz_o     out  1              rotate every buffer row by one column
//  kern_valid_o      out  1              current taps form a legal window
//  kern_col_o        out  $clog2(OUT_W)  output column of the current window
//  capture_o         out  1              write the kernel result into the output-row register
//  capture_col_o     out  $clog2(OUT_W)  column for capture_o
//  out_row_valid_o   out  1              output-row register complete
//  out_row_accept_i  in   1              downstream takes the row
//  out_row_idx_o     out  $clog2(OUT_H)  index of the presented output row
//  frame_done_o      out  1              one-cycle pulse after the last row of a frame is consumed
// BEHAVIOUR
//  Reset (async assert): every output 0, all counters 0, state FILL. Outputs stay 0 while reset_i=0.
//  First cycle after release: in_row_ready_o=1.
//  FILL: ready=1. Count rows on shift_vert_o. When the KERNAL_SIZE-th row is taken -> SCAN (col=0).
//  SCAN: exactly WIDTH cycles, col 0..WIDTH-1. shift_horiz_o=1 every cycle.
//    The datapath rotates, so the buffer is realigned after WIDTH shifts.
//    kern_valid_o=1 iff col<=WIDTH-KERNAL_SIZE and col is a multiple of STRIDE.
//    Use a phase counter; no modulo. kern_col_o increments per valid window.
//    Taps in a cycle show the pre-shift column. ready=0.
//  Capture pipe: capture_o/capture_col_o = kern_valid_o/kern_col_o delayed by exactly KERNAL_LATENCY cycles.
//  DRAIN: KERNAL_LATENCY cycles after SCAN, until the pipe is empty -> HOLD.
//  HOLD: out_row_valid_o=1 and out_row_idx_o stable until out_row_accept_i.
//    No row loads and no scan during HOLD; the output register must not be overwritten.
//    Accept in the first HOLD cycle is legal.
//    On accept with idx<OUT_H-1: idx++ -> LOAD.
//    On accept with idx=OUT_H-1: LEFTOVER>0 -> FLUSH, LEFTOVER=0 -> DONE.
//  LOAD: ready=1. Take exactly STRIDE rows -> SCAN.
//  FLUSH: ready=1. Take and discard LEFTOVER rows (shift_vert_o still pulses) -> DONE.
//  DONE: one cycle, frame_done_o=1, clear row/idx counters -> FILL.
//  in_row_valid_i gaps in FILL/LOAD/FLUSH: the state waits. No shift without valid&ready.
//  Counters are exactly sized; no wrap beyond terminal values. Async reset mid-state discards the partial frame.
// STRUCTURE
//  cnn_pkg: state enum typedef (FILL,SCAN,DRAIN,HOLD,LOAD,FLUSH,DONE).
//  cnn_pkg: functions out_dim(size,k,stride) and leftover(size,k,stride).
//  Sub-module valid_delay_line #(DEPTH,DATA_BITS): async-reset shift register carrying {valid,col} for the capture pipe.
// TESTING (default W=H=8,K=3,S=1,LAT=2 unless noted)
//  1 Release reset, 3 rows back-to-back -> 3 shift_vert pulses, ready drops.
//    Then 8 cycles of shift_horiz, kern_valid cols 0..5, capture cols 0..5 two cycles later, then out_row_valid.
//  2 Hold accept low 10 cycles in HOLD -> valid, idx, ready=0 stable, no shift_vert/shift_horiz.
//    Accept -> LOAD, one row taken.
//  3 S=2 -> kern_valid at cols 0,2,4 only (kern_col 0,1,2).
//    After accept, exactly 2 rows taken before the next SCAN.
//  4 H=8,S=2 -> 3 output rows (idx 0..2), one leftover row flushed.
//    frame_done pulses once, then FILL accepts a new frame.
//  5 reset_i low mid-SCAN -> all outputs 0 immediately.
//    After release: FILL, 3 fresh rows needed before any kern_valid.
//  6 in_row_valid toggling 1010 in FILL -> shift_vert only on valid cycles, SCAN after the 3rd.

Source files
------------

// File: rtl/cnn_row_sequencer_pkg.sv
// Shared types and dimension helpers for the CNN row sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    FILL,
    SCAN,
    DRAIN,
    HOLD,
    LOAD,
    FLUSH,
    DONE
  } seq_state_t;

  function automatic int out_dim(input int size, input int k, input int stride);
    return (size - k) / stride + 1;
  endfunction

  function automatic int leftover(input int size, input int k, input int stride);
    return size - k - (out_dim(size, k, stride) - 1) * stride;
  endfunction

  // Counter width that stays legal when only one value is needed.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_row_sequencer_valid_delay_line.sv
// Fixed-depth shift register that carries {valid, column} from the kernel
// taps to the capture point, matching the kernel latency.
module valid_delay_line #(
  parameter int DEPTH     = 2,
  parameter int DATA_BITS = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o
);

  logic [DEPTH-1:0][DATA_BITS-1:0] stage_q;
  logic [DEPTH-1:0][DATA_BITS-1:0] stage_d;

  always_comb begin
    stage_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
          stage_q[gi] <= '0;
        end else begin
          stage_q[gi] <= stage_d[gi];
        end
      end
    end
  endgenerate

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cnn_row_sequencer.sv
// Row/column control for one CNN layer: fills the line buffer, scans windows,
// times kernel-result capture and hands finished output rows downstream.
module cnn_row_sequencer
  import cnn_pkg::*;
#(
  parameter int WIDTH          = 28,
  parameter int HEIGHT         = 28,
  parameter int KERNAL_SIZE    = 3,
  parameter int STRIDE         = 1,
  parameter int KERNAL_LATENCY = 2
) (
  input  logic                                                    clock_i,
  input  logic                                                    reset_i,
  input  logic                                                    in_row_valid_i,
  output logic                                                    in_row_ready_o,
  output logic                                                    shift_vert_o,
  output logic                                                    shift_horiz_o,
  output logic                                                    kern_valid_o,
  output logic [cnt_bits(out_dim(WIDTH, KERNAL_SIZE, STRIDE))-1:0]  kern_col_o,
  output logic                                                    capture_o,
  output logic [cnt_bits(out_dim(WIDTH, KERNAL_SIZE, STRIDE))-1:0]  capture_col_o,
  output logic                                                    out_row_valid_o,
  input  logic                                                    out_row_accept_i,
  output logic [cnt_bits(out_dim(HEIGHT, KERNAL_SIZE, STRIDE))-1:0] out_row_idx_o,
  output logic                                                    frame_done_o
);

  localparam int OUT_W  = out_dim(WIDTH, KERNAL_SIZE, STRIDE);
  localparam int OUT_H  = out_dim(HEIGHT, KERNAL_SIZE, STRIDE);
  localparam int LEFT   = leftover(HEIGHT, KERNAL_SIZE, STRIDE);
  localparam int RMAX_A = (KERNAL_SIZE > STRIDE) ? KERNAL_SIZE : STRIDE;
  localparam int RMAX   = (RMAX_A > LEFT) ? RMAX_A : LEFT;

  localparam int CW = cnt_bits(WIDTH);
  localparam int KW = cnt_bits(OUT_W);
  localparam int HW = cnt_bits(OUT_H);
  localparam int RW = cnt_bits(RMAX);
  localparam int PW = cnt_bits(STRIDE);
  localparam int DW = cnt_bits(KERNAL_LATENCY);

  localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_WIN_LAST = CW'(WIDTH - KERNAL_SIZE);
  localparam logic [PW-1:0] PH_LAST      = PW'(STRIDE - 1);
  localparam logic [KW-1:0] KCOL_LAST    = KW'(OUT_W - 1);
  localparam logic [HW-1:0] IDX_LAST     = HW'(OUT_H - 1);
  localparam logic [RW-1:0] FILL_LAST    = RW'(KERNAL_SIZE - 1);
  localparam logic [RW-1:0] LOAD_LAST    = RW'(STRIDE - 1);
  localparam logic [RW-1:0] FLUSH_LAST   = RW'((LEFT > 0) ? LEFT - 1 : 0);
  localparam logic [DW-1:0] DRAIN_LAST   = DW'(KERNAL_LATENCY - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [KW-1:0] kcol_q, kcol_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] idx_q, idx_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          ready;
  logic          take;
  logic          win_valid;
  logic [KW:0]   cap_pipe;

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    phase_d         = phase_q;
    kcol_d          = kcol_q;
    row_d           = row_q;
    idx_d           = idx_q;
    drain_d         = drain_q;
    ready           = 1'b0;
    win_valid       = 1'b0;
    shift_horiz_o   = 1'b0;
    out_row_valid_o = 1'b0;
    frame_done_o    = 1'b0;

    ready = (state_q == FILL) || (state_q == LOAD) || (state_q == FLUSH);
    take  = in_row_valid_i & ready;

    case (state_q)
      FILL: begin
        if (take) begin
          if (row_q == FILL_LAST) begin
            row_d   = '0;
            state_d = SCAN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      SCAN: begin
        shift_horiz_o = 1'b1;
        // Phase counter marks every STRIDE-th column without a divider.
        win_valid     = (col_q <= COL_WIN_LAST) && (phase_q == '0);
        if (win_valid && (kcol_q != KCOL_LAST)) begin
          kcol_d = kcol_q + 1'b1;
        end
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          phase_d = '0;
          kcol_d  = '0;
          state_d = DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = HOLD;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      HOLD: begin
        out_row_valid_o = 1'b1;
        if (out_row_accept_i) begin
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = (LEFT > 0) ? FLUSH : DONE;
          end
        end
      end
      LOAD: begin
        if (take) begin
          if (row_q == LOAD_LAST) begin
            row_d   = '0;
            state_d = SCAN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (take) begin
          if (row_q == FLUSH_LAST) begin
            row_d   = '0;
            state_d = DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DONE: begin
        frame_done_o = 1'b1;
        row_d        = '0;
        idx_d        = '0;
        state_d      = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= FILL;
      col_q   <= '0;
      phase_q <= '0;
      kcol_q  <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      kcol_q  <= kcol_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  // FILL is the reset state, so ready is masked to keep it low while held in reset.
  assign in_row_ready_o = ready & reset_i;
  assign shift_vert_o   = in_row_valid_i & in_row_ready_o;
  assign kern_valid_o   = win_valid;
  assign kern_col_o     = win_valid ? kcol_q : '0;
  assign out_row_idx_o  = idx_q;

  valid_delay_line #(
    .DEPTH    (KERNAL_LATENCY),
    .DATA_BITS(KW + 1)
  ) u_capture_pipe (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .data_i ({kern_valid_o, kern_col_o}),
    .data_o (cap_pipe)
  );

  assign capture_o     = cap_pipe[KW];
  assign capture_col_o = cap_pipe[KW-1:0];

endmodule
